processing_lane_ctx: RTL



---
 rtl/processing_lane_ctx_pkg.sv | 60 ++++++
 rtl/processing_lane_ctx_regfile.sv | 44 ++++
 rtl/processing_lane_ctx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/processing_lane_ctx_pkg.sv
// Shared types for the multi-context SIMT lane: opcodes, instruction field layout, FSM states.
// Also holds small decode helpers used by the lane top.
package processing_lane_ctx_pkg;

    localparam int OPC_MSB    = 31;
    localparam int OPC_LSB    = 26;
    localparam int DST_MSB    = 25;
    localparam int DST_LSB    = 21;
    localparam int SRC1_MSB   = 20;
    localparam int SRC1_LSB   = 16;
    localparam int SRC2_MSB   = 15;
    localparam int SRC2_LSB   = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [5:0] {
        OP_NOP   = 6'h00,
        OP_ADD   = 6'h01,
        OP_SUB   = 6'h02,
        OP_MUL   = 6'h03,
        OP_AND   = 6'h04,
        OP_OR    = 6'h05,
        OP_XOR   = 6'h06,
        OP_ADDI  = 6'h07,
        OP_LOAD  = 6'h10,
        OP_STORE = 6'h11
    } lane_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_WB
    } lane_ctx_state_e;

    // Wide result; callers size-cast it down to their datapath width.
    function automatic logic [63:0] sign_extend_imm(input logic [15:0] imm);
        return {{48{imm[15]}}, imm};
    endfunction

    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR,
            OP_ADDI, OP_LOAD, OP_STORE: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    function automatic logic op_writes_reg(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR,
            OP_ADDI, OP_LOAD: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/processing_lane_ctx_regfile.sv
// NUM_CTX banks of REG_FILE_SIZE registers; three combinational reads, one synchronous write.
// r0 of each bank reads zero and ignores writes; reset clears every entry.
module lane_ctx_regfile
    import processing_lane_ctx_pkg::*;
#(
    parameter int  DATA_WIDTH    = 32,
    parameter int  REG_FILE_SIZE = 32,
    parameter int  NUM_CTX       = 4,
    localparam int CTX_W         = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CTX_W-1:0]      rd_ctx,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    input  logic [REG_ADDR_W-1:0] rd_addr_c,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic [DATA_WIDTH-1:0] rd_data_c,
    input  logic                  wr_en,
    input  logic [CTX_W-1:0]      wr_ctx,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_CTX][REG_FILE_SIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CTX; c++) begin
                for (int r = 0; r < REG_FILE_SIZE; r++) begin
                    regs_q[c][r] <= '0;
                end
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_q[wr_ctx][wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_ctx][rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_ctx][rd_addr_b];
    assign rd_data_c = (rd_addr_c == '0) ? '0 : regs_q[rd_ctx][rd_addr_c];

endmodule

// File: rtl/processing_lane_ctx.sv
// One SIMT lane with NUM_CTX register contexts; ALU done at T+3, MUL at T+2+MUL_LATENCY, masked at T+1.
// One instruction in flight: in_ready only in IDLE; memory request held stable until mem_req_ready.
module processing_lane_ctx
    import processing_lane_ctx_pkg::*;
#(
    parameter int  LANE_ID       = 0,
    parameter int  DATA_WIDTH    = 32,
    parameter int  REG_FILE_SIZE = 32,
    parameter int  NUM_CTX       = 4,
    parameter int  MUL_LATENCY   = 3,
    parameter int  ADDR_WIDTH    = 32,
    localparam int CTX_W         = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [CTX_W-1:0]      in_ctx,
    input  logic                  lane_enable,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
    output logic                  done_valid,
    output logic [CTX_W-1:0]      done_ctx,
    output logic                  done_masked,
    output logic                  illegal,
    output logic                  busy
);

    localparam int               CNT_W        = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LATENCY - 1);

    generate
        if (LANE_ID < 0 || MUL_LATENCY < 1) begin : g_param_check
            $error("processing_lane_ctx: LANE_ID must be >= 0 and MUL_LATENCY >= 1");
        end
    endgenerate

    lane_ctx_state_e state_q, state_d;

    logic [31:0]           inst_q;
    logic [CTX_W-1:0]      ctx_q;
    logic                  masked_q;
    logic [DATA_WIDTH-1:0] op_a_q;
    logic [DATA_WIDTH-1:0] op_b_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      mul_cnt_q;

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] dst_idx;
    logic [REG_ADDR_W-1:0] src1_idx;
    logic [REG_ADDR_W-1:0] src2_idx;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] alu_out;
    logic [DATA_WIDTH-1:0] rd_src1;
    logic [DATA_WIDTH-1:0] rd_src2;
    logic [DATA_WIDTH-1:0] rd_store;
    logic                  is_load;
    logic                  is_store;
    logic                  is_mul;
    logic                  use_imm;
    logic                  accept;
    logic                  rf_we;

    assign opcode   = inst_q[OPC_MSB:OPC_LSB];
    assign dst_idx  = inst_q[DST_MSB:DST_LSB];
    assign src1_idx = inst_q[SRC1_MSB:SRC1_LSB];
    assign src2_idx = inst_q[SRC2_MSB:SRC2_LSB];
    assign imm_ext  = DATA_WIDTH'(sign_extend_imm(inst_q[IMM_MSB:IMM_LSB]));

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_mul   = (opcode == OP_MUL);
    assign use_imm  = is_load || is_store || (opcode == OP_ADDI);
    assign accept   = in_valid && in_ready;

    lane_ctx_regfile #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_FILE_SIZE (REG_FILE_SIZE),
        .NUM_CTX       (NUM_CTX)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_ctx    (ctx_q),
        .rd_addr_a (src1_idx),
        .rd_addr_b (src2_idx),
        .rd_addr_c (dst_idx),
        .rd_data_a (rd_src1),
        .rd_data_b (rd_src2),
        .rd_data_c (rd_store),
        .wr_en     (rf_we),
        .wr_ctx    (ctx_q),
        .wr_addr   (dst_idx),
        .wr_data   (result_q)
    );

    always_comb begin
        alu_out = '0;
        case (opcode)
            OP_ADD, OP_ADDI: alu_out = op_a_q + op_b_q;
            OP_SUB:          alu_out = op_a_q - op_b_q;
            OP_MUL:          alu_out = op_a_q * op_b_q;
            OP_AND:          alu_out = op_a_q & op_b_q;
            OP_OR:           alu_out = op_a_q | op_b_q;
            OP_XOR:          alu_out = op_a_q ^ op_b_q;
            default:         alu_out = '0;
        endcase
    end

    // Masked instructions skip straight to WB so the scheduler still sees a completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept) state_d = lane_enable ? ST_READ : ST_WB;
            ST_READ:     state_d = (is_load || is_store) ? ST_MEM_REQ : ST_EXEC;
            ST_EXEC:     if (mul_cnt_q == '0) state_d = ST_WB;
            ST_MEM_REQ:  if (mem_req_ready) state_d = is_store ? ST_WB : ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_rsp_valid) state_d = ST_WB;
            ST_WB:       state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            inst_q    <= '0;
            ctx_q     <= '0;
            masked_q  <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            result_q  <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            mul_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        inst_q   <= in_inst;
                        ctx_q    <= in_ctx;
                        masked_q <= !lane_enable;
                    end
                end
                ST_READ: begin
                    op_a_q    <= rd_src1;
                    op_b_q    <= use_imm ? imm_ext : rd_src2;
                    wdata_q   <= rd_store;
                    addr_q    <= ADDR_WIDTH'(rd_src1 + imm_ext);
                    mul_cnt_q <= is_mul ? MUL_CNT_INIT : '0;
                end
                ST_EXEC: begin
                    result_q <= alu_out;
                    if (mul_cnt_q != '0) mul_cnt_q <= mul_cnt_q - CNT_W'(1);
                end
                ST_MEM_WAIT: begin
                    if (mem_rsp_valid) result_q <= mem_rsp_rdata;
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign mem_req_valid = (state_q == ST_MEM_REQ);
    assign mem_req_we    = mem_req_valid && is_store;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign done_valid    = (state_q == ST_WB);
    assign done_ctx      = ctx_q;
    assign done_masked   = done_valid && masked_q;
    assign illegal       = done_valid && !masked_q && !op_is_legal(opcode);
    assign rf_we         = done_valid && !masked_q && op_writes_reg(opcode);

endmodule
